frame_window_streamer: RTL and testbench

FRAME_WINDOW_STREAMER -- requirements
Module: frame_window_streamer

---
 rtl/fws_pkg.sv | 48 ++++
 rtl/fws_quant.sv | 56 +++++
 rtl/frame_window_streamer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_frame_window_streamer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fws_pkg.sv
// ---------------------------------------------------------------------------
// fws_pkg
// Shared definitions for frame_window_streamer:
//   - fws_state_e : frame controller states (FILL / HOP / EMIT)
//   - default sample / coefficient / output formats and frame length
//   - derived constants NB_PROD, NBF_PROD, NBI_TRUNC, ADDR_W for the defaults
//   - constant functions that derive the same values from any parameter set
// ---------------------------------------------------------------------------
package fws_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HOP  = 2'd1,
        EMIT = 2'd2
    } fws_state_e;

    localparam int DEF_NP          = 1024;
    localparam int DEF_NB_SAMPLES  = 16;
    localparam int DEF_NBF_SAMPLES = 15;
    localparam int DEF_NB_WINDOWS  = 10;
    localparam int DEF_NBF_WINDOWS = 7;
    localparam int DEF_NB_OUTPUT   = 16;
    localparam int DEF_NBF_OUTPUT  = 15;

    // Full-precision product width and fractional bits.
    function automatic int nb_prod(input int nb_s, input int nb_w);
        return nb_s + nb_w;
    endfunction

    function automatic int nbf_prod(input int nbf_s, input int nbf_w);
        return nbf_s + nbf_w;
    endfunction

    // Width left after dropping the fractional bits the output does not keep.
    function automatic int nbi_trunc(input int nb_p, input int nbf_p, input int nbf_o);
        return nb_p - (nbf_p - nbf_o);
    endfunction

    function automatic int addr_w(input int np);
        return $clog2(np);
    endfunction

    localparam int NB_PROD   = nb_prod(DEF_NB_SAMPLES, DEF_NB_WINDOWS);
    localparam int NBF_PROD  = nbf_prod(DEF_NBF_SAMPLES, DEF_NBF_WINDOWS);
    localparam int NBI_TRUNC = nbi_trunc(NB_PROD, NBF_PROD, DEF_NBF_OUTPUT);
    localparam int ADDR_W    = addr_w(DEF_NP);

endpackage

// File: rtl/fws_quant.sv
// ---------------------------------------------------------------------------
// fws_quant
// Combinational requantiser: signed NB_IN/NBF_IN -> signed NB_OUT/NBF_OUT.
// Drops NBF_IN-NBF_OUT fractional bits (floor), optionally adding half an
// output LSB first (round-half-up), then saturates to the output range.
//   i_data : full-precision signed input
//   o_data : quantised, saturated signed output
// Build option: define FWS_ROUND_EN to enable round-half-up.
// ---------------------------------------------------------------------------
module fws_quant
    import fws_pkg::*;
#(
    parameter int NB_IN   = NB_PROD,
    parameter int NBF_IN  = NBF_PROD,
    parameter int NB_OUT  = DEF_NB_OUTPUT,
    parameter int NBF_OUT = DEF_NBF_OUTPUT
) (
    input  logic signed [NB_IN-1:0]  i_data,
    output logic signed [NB_OUT-1:0] o_data
);

    localparam int SH  = NBF_IN - NBF_OUT;
    localparam int NBT = nbi_trunc(NB_IN, NBF_IN, NBF_OUT);
    // One guard bit so that the rounding add can never wrap.
    localparam int NBW = NB_IN + 1;
    localparam int RSH = (SH > 0) ? SH - 1 : 0;

`ifdef FWS_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    localparam logic [NBW-1:0] RND_C = (ROUND_EN && (SH > 0)) ? (NBW'(1) << RSH) : NBW'(0);

    logic signed [NBW-1:0] ext_s;
    logic signed [NBW-1:0] rnd_s;
    logic signed [NBT:0]   trn_s;
    logic [NBT-NB_OUT+1:0] top_s;

    // Round (optional), floor by dropping low bits, then saturate.
    always_comb begin
        ext_s = {i_data[NB_IN-1], i_data};
        rnd_s = ext_s + $signed(RND_C);
        trn_s = rnd_s[NBW-1:SH];
        top_s = trn_s[NBT:NB_OUT-1];
        if ((&top_s) || !(|top_s)) begin
            o_data = trn_s[NB_OUT-1:0];
        end else if (trn_s[NBT]) begin
            o_data = {1'b1, {(NB_OUT-1){1'b0}}};
        end else begin
            o_data = {1'b0, {(NB_OUT-1){1'b1}}};
        end
    end

endmodule

// File: rtl/frame_window_streamer.sv
// ---------------------------------------------------------------------------
// frame_window_streamer
// Buffers NCH channels of samples in circular buffers of depth NP and, once a
// frame is ready (NP samples after reset, then every L new samples), streams
// the last NP samples per channel oldest-first, optionally multiplied by a
// window coefficient read from an external ROM.
// Ports:
//   clock, i_reset (async, active-high)
//   i_hop        : hop size L (0 or > NP means NP), latched on HOP entry
//   i_win_sel    : 00 bypass, else multiply; latched on EMIT entry
//   i_x/i_x_valid/o_x_ready : sample input stream (ready low while emitting)
//   o_coeff_addr/o_coeff_en/i_coeff : window ROM port, data one cycle after en
//   o_y/o_y_valid/i_y_ready/o_y_last : windowed output stream
// Build option: FWS_ROUND_EN selects round-half-up quantisation (fws_quant).
// Pipeline: issue -> buffer/ROM read -> multiply -> quantise/register, so the
// first output is valid 3 cycles after EMIT entry. The ROM read port is
// expected to hold its output while o_coeff_en is low.
// ---------------------------------------------------------------------------
module frame_window_streamer
    import fws_pkg::*;
#(
    parameter int NCH         = 2,
    parameter int NP          = DEF_NP,
    parameter int NB_SAMPLES  = DEF_NB_SAMPLES,
    parameter int NBF_SAMPLES = DEF_NBF_SAMPLES,
    parameter int NB_WINDOWS  = DEF_NB_WINDOWS,
    parameter int NBF_WINDOWS = DEF_NBF_WINDOWS,
    parameter int NB_OUTPUT   = DEF_NB_OUTPUT,
    parameter int NBF_OUTPUT  = DEF_NBF_OUTPUT
) (
    input  logic                        clock,
    input  logic                        i_reset,
    input  logic [$clog2(NP):0]         i_hop,
    input  logic [1:0]                  i_win_sel,
    input  logic [NCH*NB_SAMPLES-1:0]   i_x,
    input  logic                        i_x_valid,
    output logic                        o_x_ready,
    output logic [$clog2(NP)-1:0]       o_coeff_addr,
    output logic                        o_coeff_en,
    input  logic [NB_WINDOWS-1:0]       i_coeff,
    output logic [NCH*NB_OUTPUT-1:0]    o_y,
    output logic                        o_y_valid,
    input  logic                        i_y_ready,
    output logic                        o_y_last
);

    localparam int AW   = addr_w(NP);
    localparam int CW   = AW + 1;
    localparam int NBP  = nb_prod(NB_SAMPLES, NB_WINDOWS);
    localparam int NBFP = nbf_prod(NBF_SAMPLES, NBF_WINDOWS);
    localparam logic [CW-1:0] NP_C   = CW'(NP);
    localparam logic [AW-1:0] KMAX_C = AW'(NP - 1);

    fws_state_e state_r, state_s;

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] hop_r;
    logic [CW-1:0] hop_eff_s;
    logic [AW-1:0] wp_r;
    logic [1:0]    win_r;
    logic          x_ready_r;

    logic [NB_SAMPLES-1:0] mem_r [NCH][NP];

    logic          a_v_r;
    logic [AW-1:0] k_a_r;
    logic          b_v_r, b_last_r;
    logic signed [NB_SAMPLES-1:0] smp_b_r [NCH];
    logic          c_v_r, c_last_r;
    logic signed [NBP-1:0] prod_c_r [NCH];
    logic signed [NBP-1:0] prod_s   [NCH];
    logic signed [NB_OUTPUT-1:0] q_s [NCH];
    logic          y_v_r, y_last_r;
    logic [NCH*NB_OUTPUT-1:0] y_r;

    logic signed [NB_WINDOWS-1:0] coeff_s;
    logic acc_s, adv_s, mult_s, last_out_s, enter_emit_s;

    assign acc_s      = i_x_valid && x_ready_r;
    // Whole pipeline freezes while the output beat is refused.
    assign adv_s      = !(y_v_r && !i_y_ready);
    assign mult_s     = (win_r != 2'b00);
    assign last_out_s = y_v_r && y_last_r && i_y_ready;
    assign coeff_s    = i_coeff;
    assign hop_eff_s  = ((i_hop == '0) || (i_hop > NP_C)) ? NP_C : i_hop;

    // Next-state logic for the FILL / HOP / EMIT controller.
    always_comb begin
        state_s      = state_r;
        enter_emit_s = 1'b0;
        case (state_r)
            FILL: begin
                if (acc_s && (cnt_r == (NP_C - CW'(1)))) begin
                    state_s      = EMIT;
                    enter_emit_s = 1'b1;
                end else begin
                    state_s = FILL;
                end
            end
            HOP: begin
                if (acc_s && ((cnt_r + CW'(1)) == hop_r)) begin
                    state_s      = EMIT;
                    enter_emit_s = 1'b1;
                end else begin
                    state_s = HOP;
                end
            end
            EMIT: begin
                if (last_out_s) begin
                    state_s = HOP;
                end else begin
                    state_s = EMIT;
                end
            end
            default: begin
                state_s = FILL;
            end
        endcase
    end

    // Controller state, sample counter, write pointer and latched settings.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state_r   <= FILL;
            cnt_r     <= '0;
            hop_r     <= NP_C;
            wp_r      <= '0;
            win_r     <= 2'b00;
            x_ready_r <= 1'b1;
        end else begin
            state_r   <= state_s;
            x_ready_r <= (state_s != EMIT);
            if (acc_s) begin
                wp_r <= wp_r + AW'(1);
            end
            if (state_s != state_r) begin
                cnt_r <= '0;
            end else if (acc_s) begin
                cnt_r <= cnt_r + CW'(1);
            end
            // L only changes when a new HOP phase starts.
            if ((state_r == EMIT) && (state_s == HOP)) begin
                hop_r <= hop_eff_s;
            end
            if (enter_emit_s) begin
                win_r <= i_win_sel;
            end
        end
    end

    // Per-channel circular sample buffers.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            for (int c = 0; c < NCH; c++) begin
                for (int i = 0; i < NP; i++) begin
                    mem_r[c][i] <= '0;
                end
            end
        end else if (acc_s) begin
            for (int c = 0; c < NCH; c++) begin
                mem_r[c][wp_r] <= i_x[c*NB_SAMPLES +: NB_SAMPLES];
            end
        end
    end

    // Issue stage: frame index k, which is also the window ROM address.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            a_v_r <= 1'b0;
            k_a_r <= '0;
        end else if (enter_emit_s) begin
            a_v_r <= 1'b1;
            k_a_r <= '0;
        end else if (adv_s && a_v_r) begin
            if (k_a_r == KMAX_C) begin
                a_v_r <= 1'b0;
            end else begin
                k_a_r <= k_a_r + AW'(1);
            end
        end
    end

    // Read stage: sample at wp+k is read while the ROM fetches coefficient k.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            b_v_r    <= 1'b0;
            b_last_r <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                smp_b_r[c] <= '0;
            end
        end else if (adv_s) begin
            b_v_r    <= a_v_r;
            b_last_r <= a_v_r && (k_a_r == KMAX_C);
            for (int c = 0; c < NCH; c++) begin
                smp_b_r[c] <= mem_r[c][wp_r + k_a_r];
            end
        end
    end

    // Window product; bypass aligns the sample to the product's binary point.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            if (mult_s) begin
                prod_s[c] = NBP'(smp_b_r[c]) * NBP'(coeff_s);
            end else begin
                prod_s[c] = NBP'(smp_b_r[c]) <<< NBF_WINDOWS;
            end
        end
    end

    // Multiply stage register.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            c_v_r    <= 1'b0;
            c_last_r <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                prod_c_r[c] <= '0;
            end
        end else if (adv_s) begin
            c_v_r    <= b_v_r;
            c_last_r <= b_last_r;
            for (int c = 0; c < NCH; c++) begin
                prod_c_r[c] <= prod_s[c];
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        fws_quant #(
            .NB_IN   (NBP),
            .NBF_IN  (NBFP),
            .NB_OUT  (NB_OUTPUT),
            .NBF_OUT (NBF_OUTPUT)
        ) u_quant (
            .i_data (prod_c_r[g]),
            .o_data (q_s[g])
        );
    end

    // Output register stage.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            y_v_r    <= 1'b0;
            y_last_r <= 1'b0;
            y_r      <= '0;
        end else if (adv_s) begin
            y_v_r    <= c_v_r;
            y_last_r <= c_last_r;
            for (int c = 0; c < NCH; c++) begin
                y_r[c*NB_OUTPUT +: NB_OUTPUT] <= q_s[c];
            end
        end
    end

    assign o_x_ready    = x_ready_r;
    assign o_coeff_addr = k_a_r;
    // The ROM is only read on an edge where the issue stage actually moves.
    assign o_coeff_en   = a_v_r && mult_s && adv_s;
    assign o_y          = y_r;
    assign o_y_valid    = y_v_r;
    assign o_y_last     = y_last_r;

endmodule

// File: tb/tb_frame_window_streamer.sv
// ---------------------------------------------------------------------------
// tb_frame_window_streamer
// Directed bench for frame_window_streamer with NCH=1, NP=8.
// ---------------------------------------------------------------------------
module tb_frame_window_streamer;

    localparam int NCH = 1;
    localparam int NP  = 8;

    logic        clock;
    logic        i_reset;
    logic [3:0]  i_hop;
    logic [1:0]  i_win_sel;
    logic [15:0] i_x;
    logic        i_x_valid;
    logic        o_x_ready;
    logic [2:0]  o_coeff_addr;
    logic        o_coeff_en;
    logic [9:0]  i_coeff;
    logic [15:0] o_y;
    logic        o_y_valid;
    logic        i_y_ready;
    logic        o_y_last;

    int checks = 0;
    int errors = 0;

    logic [9:0]  rom [NP];
    logic [15:0] got_y    [16];
    logic        got_last [16];
    logic [15:0] exp_y    [NP];
    bit          en_seen;
    int          nb, first;
    bit          done, vflag;

    frame_window_streamer #(
        .NCH (NCH),
        .NP  (NP)
    ) dut (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_hop        (i_hop),
        .i_win_sel    (i_win_sel),
        .i_x          (i_x),
        .i_x_valid    (i_x_valid),
        .o_x_ready    (o_x_ready),
        .o_coeff_addr (o_coeff_addr),
        .o_coeff_en   (o_coeff_en),
        .i_coeff      (i_coeff),
        .o_y          (o_y),
        .o_y_valid    (o_y_valid),
        .i_y_ready    (i_y_ready),
        .o_y_last     (o_y_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Window ROM with enabled read port: output holds while en is low.
    always @(posedge clock) begin
        if (o_coeff_en) i_coeff <= rom[o_coeff_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] v);
        int t = 0;
        while (!o_x_ready && t < 50) begin
            @(posedge clock); #1;
            t++;
        end
        chk("push_ready_wait", (t < 50), 1);
        i_x = v;
        i_x_valid = 1'b1;
        @(posedge clock); #1;
        i_x_valid = 1'b0;
    endtask

    task automatic get_frame(input bit rnd, output int n, output int f, output bit d);
        n = 0; f = -1; d = 1'b0; en_seen = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            i_y_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            #1;
            if (o_coeff_en) en_seen = 1'b1;
            if (o_y_valid && !i_y_ready) chk("stall_coeff_en", o_coeff_en, 0);
            if (o_y_valid && i_y_ready) begin
                if (f < 0) f = cyc;
                if (n < 16) begin
                    got_y[n] = o_y;
                    got_last[n] = o_y_last;
                end
                n++;
                if (o_y_last) d = 1'b1;
            end
            @(posedge clock); #1;
            if (d) break;
        end
        i_y_ready = 1'b1;
    endtask

    task automatic chk_frame(input string tag, input bit exp_en);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_beats"}, nb, NP);
        for (int i = 0; i < NP; i++) begin
            chk($sformatf("%s_y%0d", tag, i), got_y[i], exp_y[i]);
            chk($sformatf("%s_last%0d", tag, i), got_last[i], (i == NP - 1));
        end
        chk({tag, "_coeff_en"}, en_seen, exp_en);
        chk({tag, "_valid_after"}, o_y_valid, 0);
        chk({tag, "_ready_after"}, o_x_ready, 1);
    endtask

    initial begin
        i_reset = 1'b1; i_hop = 4'd4; i_win_sel = 2'b00;
        i_x = 16'h0000; i_x_valid = 1'b0; i_y_ready = 1'b1; i_coeff = 10'd0;
        for (int i = 0; i < NP; i++) rom[i] = 10'd64;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_x_ready", o_x_ready, 1);
        chk("rst_y_valid", o_y_valid, 0);
        chk("rst_y_last", o_y_last, 0);
        chk("rst_coeff_en", o_coeff_en, 0);
        chk("rst_coeff_addr", o_coeff_addr, 0);
        chk("rst_y", o_y, 0);
        i_reset = 1'b0;
        @(posedge clock); #1;

        // Frame 1: FILL with ramp 1..8, bypass.
        for (int i = 1; i <= 8; i++) push(16'(i));
        chk("f1_emit_ready", o_x_ready, 0);
        get_frame(1'b0, nb, first, done);
        chk("f1_latency", first, 3);
        for (int i = 0; i < NP; i++) exp_y[i] = 16'(i + 1);
        chk_frame("f1", 1'b0);

        // Frame 2: hop 4 -> 5..12; i_hop=0 takes effect at the next HOP.
        i_hop = 4'd0;
        for (int i = 9; i <= 12; i++) push(16'(i));
        chk("f2_emit_ready", o_x_ready, 0);
        get_frame(1'b0, nb, first, done);
        chk("f2_latency", first, 3);
        for (int i = 0; i < NP; i++) exp_y[i] = 16'(i + 5);
        chk_frame("f2", 1'b0);

        // Frame 3: multiply mode, hop 0 means a whole new frame.
        i_win_sel = 2'b01; i_hop = 4'd2;
        rom[2] = 10'd384; rom[3] = 10'd384;
        push(16'h4000); push(16'h4000); push(16'h7FFF); push(16'h8000);
        push(16'h0100); push(16'hFF00); push(16'h4000);
        chk("hop0_ready_at7", o_x_ready, 1);
        push(16'h2000);
        i_win_sel = 2'b00;
        get_frame(1'b0, nb, first, done);
        exp_y[0] = 16'h2000; exp_y[1] = 16'h2000; exp_y[2] = 16'h7FFF; exp_y[3] = 16'h8000;
        exp_y[4] = 16'h0080; exp_y[5] = 16'hFF80; exp_y[6] = 16'h2000; exp_y[7] = 16'h1000;
        chk_frame("f3", 1'b1);

        // Frame 4: hop 2 latched; change to 4 mid-HOP applies later.
        push(16'h0011);
        i_hop = 4'd4;
        chk("hop2_ready_at1", o_x_ready, 1);
        push(16'h0022);
        chk("hop2_emit_ready", o_x_ready, 0);
        get_frame(1'b0, nb, first, done);
        exp_y[0] = 16'h7FFF; exp_y[1] = 16'h8000; exp_y[2] = 16'h0100; exp_y[3] = 16'hFF00;
        exp_y[4] = 16'h4000; exp_y[5] = 16'h2000; exp_y[6] = 16'h0011; exp_y[7] = 16'h0022;
        chk_frame("f4", 1'b0);

        // Frame 5: hop 4 now in force, random output stalls.
        push(16'h0031); push(16'h0032); push(16'h0033);
        chk("hop4_ready_at3", o_x_ready, 1);
        push(16'h0034);
        chk("hop4_emit_ready", o_x_ready, 0);
        get_frame(1'b1, nb, first, done);
        exp_y[0] = 16'h4000; exp_y[1] = 16'h2000; exp_y[2] = 16'h0011; exp_y[3] = 16'h0022;
        exp_y[4] = 16'h0031; exp_y[5] = 16'h0032; exp_y[6] = 16'h0033; exp_y[7] = 16'h0034;
        chk_frame("f5", 1'b0);

        // Reset while k=3 of the next frame is on the output.
        push(16'h0041); push(16'h0042); push(16'h0043); push(16'h0044);
        nb = 0;
        i_y_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (o_y_valid) begin
                if (nb == 3) break;
                nb++;
            end
            @(posedge clock); #1;
        end
        chk("rst_k3_reached", nb, 3);
        chk("rst_k3_value", o_y, 16'h0034);
        i_reset = 1'b1;
        #1;
        chk("rst_mid_valid", o_y_valid, 0);
        chk("rst_mid_last", o_y_last, 0);
        @(posedge clock); #1;
        chk("rst_mid_valid_edge", o_y_valid, 0);
        i_reset = 1'b0;
        chk("rst_mid_ready", o_x_ready, 1);
        vflag = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
            if (o_y_valid || o_y_last) vflag = 1'b1;
        end
        chk("rst_no_partial", vflag, 0);
        for (int i = 1; i <= 7; i++) push(16'(16'h0100 + i));
        repeat (4) begin
            @(posedge clock); #1;
            if (o_y_valid) vflag = 1'b1;
        end
        chk("refill_no_output_at7", vflag, 0);
        chk("refill_ready_at7", o_x_ready, 1);
        push(16'h0108);
        get_frame(1'b0, nb, first, done);
        chk("f6_latency", first, 3);
        for (int i = 0; i < NP; i++) exp_y[i] = 16'(16'h0101 + i);
        chk_frame("f6", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
